// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave synchronizer.
package spi_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RX_WIDTH    = 16;
    localparam int unsigned RX_CNT_W    = $clog2(RX_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Registered control outputs of the slave FSM.
    typedef struct packed {
        logic sel;
        logic si;
        logic reset_flag;
        logic valid_flag;
    } ctl_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with optional third flop for rise/fall pulse detection.
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic dly_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_q <= RST_VAL;
                end else begin
                    dly_q <= q;
                end
            end

            assign rise_c = q & ~dly_q;
            assign fall_c = ~q & dly_q;
        end else begin : g_no_edge
            assign rise_c = 1'b0;
            assign fall_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave front end: pin synchronization, transaction FSM and MISO drive.
// Optional 16-bit receive word assembly is enabled with SPI_RX_WORD_EN.
module spi_slave_sync
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic sel,
    output logic si,
    output logic reset_flag,
    output logic valid_flag,
    input  logic so
`ifdef SPI_RX_WORD_EN
    ,
    output logic [RX_WIDTH-1:0] rx_word,
    output logic                rx_valid
`endif
);

    logic sck_q_unused, sck_rise_c, sck_fall_c;
    logic cs_q, cs_rise_unused, cs_fall_c;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_sck),
        .q      (sck_q_unused),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    spi_edge_sync #(.RST_VAL(1'b1), .EDGE_EN(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_cs_n),
        .q      (cs_q),
        .rise_c (cs_rise_unused),
        .fall_c (cs_fall_c)
    );

    spi_edge_sync #(.RST_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (spi_mosi),
        .q      (mosi_q),
        .rise_c (mosi_rise_unused),
        .fall_c (mosi_fall_unused)
    );

    // A cs_n fall is only honoured once a genuine high has been seen after reset,
    // so a chip-select already low at reset release does not open a transaction.
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            if (warm_q[SYNC_STAGES-1] && cs_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;
    logic   sample_c;

    assign sample_c = (state_q == ACTIVE) && !cs_q && sck_rise_c;

    always_comb begin
        state_d          = state_q;
        ctl_d            = ctl_q;
        ctl_d.reset_flag = 1'b0;
        ctl_d.valid_flag = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_c && armed_q) begin
                    state_d          = START;
                    ctl_d.reset_flag = 1'b1;
                end
            end
            START: begin
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (cs_q) begin
                    state_d = IDLE;
                end else begin
                    if (sck_rise_c) begin
                        ctl_d.si = mosi_q;
                    end
                    if (sck_fall_c) begin
                        ctl_d.valid_flag = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ctl_d.sel = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctl_q       <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            spi_miso    <= ctl_q.sel ? so : 1'b0;
            spi_miso_oe <= ctl_q.sel;
        end
    end

    assign sel        = ctl_q.sel;
    assign si         = ctl_q.si;
    assign reset_flag = ctl_q.reset_flag;
    assign valid_flag = ctl_q.valid_flag;

`ifdef SPI_RX_WORD_EN
    logic [RX_WIDTH-1:0] shift_q;
    logic [RX_CNT_W-1:0] cnt_q;

    // MSB-first word assembly; the count restarts whenever the FSM leaves ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state_q != ACTIVE) begin
                cnt_q <= '0;
            end else if (sample_c) begin
                shift_q <= {shift_q[RX_WIDTH-2:0], mosi_q};
                cnt_q   <= cnt_q + RX_CNT_W'(1);
                if (cnt_q == RX_CNT_W'(RX_WIDTH - 1)) begin
                    rx_word  <= {shift_q[RX_WIDTH-2:0], mosi_q};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: bench acts as SPI master and downstream controller.
module tb_spi_slave_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        so = 1'b0;
    logic        spi_miso, spi_miso_oe, sel, si, reset_flag, valid_flag;
`ifdef SPI_RX_WORD_EN
    logic [15:0] rx_word;
    logic        rx_valid;
`endif

    spi_slave_sync dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .sel         (sel),
        .si          (si),
        .reset_flag  (reset_flag),
        .valid_flag  (valid_flag),
        .so          (so)
`ifdef SPI_RX_WORD_EN
        ,
        .rx_word     (rx_word),
        .rx_valid    (rx_valid)
`endif
    );

    always #5 clk = ~clk;

    localparam int K_RST = 0;
    localparam int K_RX  = 1;
    localparam int K_END = 2;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    chk_t        chk_q[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          vcnt = 0;
    int          vtotal = 0;
    int          rtotal = 0;
    logic        prev_sel = 1'b0;
    logic [15:0] so_word = 16'h0;
    int          so_idx = 0;

    function automatic logic [31:0] outs();
        logic [31:0] o;
        o = 32'({sel, si, reset_flag, valid_flag, spi_miso, spi_miso_oe});
`ifdef SPI_RX_WORD_EN
        o = o | 32'({rx_word, rx_valid}) << 6;
`endif
        return o;
    endfunction

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic void tally(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void take(input int kind, input string name, input logic [31:0] act);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s unexpected event actual=%0h t=%0t", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s event kind actual=%0d required=%0d", name, kind, e.kind);
            end else begin
                tally(name, act, e.val);
            end
        end
    endfunction

    // Monitor: tallies posted comparisons and scoreboards DUT output events.
    always @(negedge clk) begin
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            tally(c.name, c.act, c.exp);
        end
        if (valid_flag) begin
            vcnt++;
            vtotal++;
        end
        if (reset_flag) begin
            rtotal++;
            vcnt = 0;
            take(K_RST, "sel_at_start", 32'(sel));
        end
`ifdef SPI_RX_WORD_EN
        if (rx_valid) take(K_RX, "rx_word", 32'(rx_word));
`endif
        if (prev_sel && !sel) take(K_END, "valid_count", 32'(vcnt));
        prev_sel = sel;
    end

    // Downstream controller: presents the next MISO bit on each advance.
    always @(negedge clk) begin
        if (reset_flag) begin
            so     = so_word[15];
            so_idx = 14;
        end else if (valid_flag) begin
            if (so_idx >= 0) begin
                so = so_word[4'(so_idx)];
                so_idx--;
            end else begin
                so = 1'b0;
            end
        end
    end

    task automatic xfer(input logic [15:0] mo, input logic [15:0] sw, input int nbits,
                        input bit raise_cs, input bit abort_last, output logic [15:0] mi);
        int nv;
        nv      = abort_last ? nbits - 1 : nbits;
        so_word = sw;
        mi      = 16'h0;
        expect_ev(K_RST, 32'd1);
`ifdef SPI_RX_WORD_EN
        if (nbits == 16 && !abort_last) expect_ev(K_RX, 32'(mo));
`endif
        expect_ev(K_END, 32'(nv));
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
        post("reset_flag_early", 32'(reset_flag), 32'd0);
        @(negedge clk);
        post("reset_flag_at3", 32'(reset_flag), 32'd1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[4'(15 - i)];
            repeat (4) @(negedge clk);
            mi[4'(15 - i)] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
            if (abort_last && i == nbits - 1) spi_cs_n = 1'b1;
            repeat (2) @(negedge clk);
            post("valid_early", 32'(valid_flag), 32'd0);
            @(negedge clk);
            post("valid_at3", 32'(valid_flag), (abort_last && i == nbits - 1) ? 32'd0 : 32'd1);
        end
        if (raise_cs && !abort_last) begin
            repeat (4) @(negedge clk);
            spi_cs_n = 1'b1;
        end
        if (raise_cs || abort_last) repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] mi;
        logic        si_before;
        int          v_before, r_before;

        repeat (3) @(negedge clk);
        post("outs_in_reset", outs(), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        post("sel_idle", 32'(sel), 32'd0);

        xfer(16'h1234, 16'hA5C3, 16, 1'b1, 1'b0, mi);
        post("miso_word_a5c3", 32'(mi), 32'h0000A5C3);
        post("si_last_bit", 32'(si), 32'd0);

        xfer(16'h0F0F, 16'h0000, 7, 1'b0, 1'b1, mi);
        post("sel_after_abort", 32'(sel), 32'd0);

        xfer(16'hBEEF, 16'h5A5A, 16, 1'b1, 1'b0, mi);
        post("miso_word_5a5a", 32'(mi), 32'h00005A5A);
        post("si_after_beef", 32'(si), 32'd1);

        // SCK activity with chip-select deasserted must be ignored.
        si_before = si;
        v_before  = vtotal;
        spi_mosi  = ~si;
        for (int i = 0; i < 10; i++) begin
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        post("idle_valid_count", 32'(vtotal), 32'(v_before));
        post("idle_si", 32'(si), 32'(si_before));
        post("idle_miso_oe", 32'(spi_miso_oe), 32'd0);

        // Reset in the middle of a word, then release with cs_n still low.
        xfer(16'hF00D, 16'hFFFF, 5, 1'b0, 1'b0, mi);
        #2 rst_n = 1'b0;
        #1 post("outs_mid_reset", outs(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        r_before = rtotal;
        repeat (12) @(negedge clk);
        post("no_start_after_reset", 32'(rtotal), 32'(r_before));
        post("sel_after_reset", 32'(sel), 32'd0);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);

        xfer(16'h8001, 16'h7FFE, 16, 1'b1, 1'b0, mi);
        post("miso_word_7ffe", 32'(mi), 32'h00007FFE);

        repeat (4) @(negedge clk);
        post("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
